trivium_host_ctrl: RTL and testbench
====================================

Name: trivium_host_ctrl

Overview:
Host-side driver for the Trivium cipher core. It resets the core and loads an 80-bit key serially, then waits for core initialisation to finish. It then issues one plaintext byte per 256-byte keystream block and captures every ciphertext byte the core emits into an output FIFO. The block sits between the system byte stream (valid/ready) and the core's strobe/status interface, and generates the core's fifo_cnd flow-control code.

Parameters:
FIFO_DEPTH, 512, output FIFO entries; power of 2, must be ≥ BLOCK_LEN.
BLOCK_LEN, 256, bytes the core emits per strob_data.
INIT_TIMEOUT, 2048, cycles allowed from end of key load to core ready (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: (re)key and begin session
key_in  in  80  key; sampled on start
din  in  8  plaintext byte
din_valid  in  1  plaintext valid
din_ready  out  1  plaintext accepted this cycle
dout  out  8  ciphertext byte (FIFO head)
dout_valid  out  1  FIFO not empty
dout_ready  in  1  consumer pops head
core_rst_n  out  1  registered reset to core
core_key  out  1  serial key bit
core_strob_key  out  1  key strobe
core_data  out  8  byte to core
core_strob_data  out  1  data strobe
core_fifo_cnd  out  2  flow-control code to core
core_stream  in  8  ciphertext from core
core_wt_sgn  in  1  core_stream valid
core_sign_reg  in  8  core one-hot status; 0x04 = waiting for data
busy  out  1  high in every state except IDLE and ERR
err  out  1  sticky error

Behaviour:
- Reset values: all outputs 0 except core_rst_n=1; FIFO empty; state IDLE.
- IDLE: on start, latch key_in into key_sh, clear err, go CRST.
- CRST: core_rst_n=0 for exactly 1 cycle, then KEY. Re-keying always passes through CRST because the core's key counter clears only on its reset.
- KEY: 81 cycles with core_strob_key=1, counter k=0..80. core_key = key_sh[79] for k=0 and k=1, and key_sh[80-k] for k≥2. The core keeps the last 80 bits, k=1..80, MSB first. Then go WAIT_INIT.
- WAIT_INIT: go READY when core_sign_reg==0x04.
- READY: when din_valid && core_sign_reg==0x04 && core_fifo_cnd==2'b00, drive core_data=din, core_strob_data=1 and din_ready=1 for that cycle; clear byte counter bc; go BLOCK. core_data holds its last value at all other times.
- BLOCK: each core_wt_sgn pushes core_stream into the FIFO and increments bc. When bc reaches BLOCK_LEN, go READY. din_ready=0.
- core_fifo_cnd, combinational from FIFO count: 2'b00 if free ≥ BLOCK_LEN; 2'b11 if full; else 2'b01.
- FIFO: dout_valid = !empty. A pop happens when dout_valid && dout_ready. A push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped, err=1 and the state goes to ERR.
- Count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- ERR: all core strobes 0; FIFO still drains; start goes to CRST. FIFO contents are kept across start.
- start is ignored outside IDLE and ERR.
- core_wt_sgn outside BLOCK: push anyway, set err, go ERR.
- Asynchronous rst mid-operation: immediate return to reset values; FIFO contents are lost.

Optional Feature:
TRIVIUM_HOST_INIT_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT_INIT. If INIT_TIMEOUT cycles pass without core_sign_reg==0x04, set err and go ERR.
- Not defined: WAIT_INIT waits indefinitely and the counter logic is absent.

Test Plan:
- Key load: rst, start with key_in=80'h0123456789ABCDEF0123 → core_rst_n low 1 cycle, then core_strob_key high 81 cycles; the serial bits at k=1..80 reproduce 0x0123456789ABCDEF0123 MSB first.
- Single block: core model returns 0x04, din=0x5A with din_valid=1 → din_ready and core_strob_data high on the same cycle with core_data=0x5A. 256 core_wt_sgn pulses fill the FIFO to 256, then READY.
- Backpressure: dout_ready=0 across one block (FIFO_DEPTH=512, count 256) → core_fifo_cnd=00. After a second block, count=512 and core_fifo_cnd=11. A third din is not accepted until count ≤256.
- Overflow: FIFO full, dout_ready=0, extra core_wt_sgn → err=1, state ERR, count stays 512. start → CRST and err clears.
- Timeout (macro on, INIT_TIMEOUT=2048): core_sign_reg held 0x02 → err asserts 2048 cycles after KEY ends. With the macro off, no err after 5000 cycles.
- Reset mid-BLOCK after 100 bytes → all outputs return to reset values, dout_valid=0, core_rst_n=1.

Source files
------------

// File: rtl/trivium_host_ctrl.sv
// Trivium host driver: resets the core, loads an 80-bit key serially, then feeds one plaintext byte per keystream block.
// Latency: 1 cycle core reset + 81 key cycles; plaintext is accepted combinationally, and every ciphertext byte is written into the FIFO on the cycle it arrives.
// Backpressure: din is accepted only when the FIFO can hold a whole block; a push into a full FIFO drops the byte and raises err. Optional macro: TRIVIUM_HOST_INIT_TIMEOUT_EN.
module trivium_host_ctrl #(
    parameter int FIFO_DEPTH   = 512,
    parameter int BLOCK_LEN    = 256,
    parameter int INIT_TIMEOUT = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [79:0] i_key_in,
    input  logic [7:0]  i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    output logic [7:0]  o_dout,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic        o_core_rst_n,
    output logic        o_core_key,
    output logic        o_core_strob_key,
    output logic [7:0]  o_core_data,
    output logic        o_core_strob_data,
    output logic [1:0]  o_core_fifo_cnd,
    input  logic [7:0]  i_core_stream,
    input  logic        i_core_wt_sgn,
    input  logic [7:0]  i_core_sign_reg,
    output logic        o_busy,
    output logic        o_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(BLOCK_LEN) + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_OPEN = CW'(FIFO_DEPTH - BLOCK_LEN);
    localparam logic [BCW-1:0] BC_LAST  = BCW'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_KEY, S_WAIT_INIT, S_READY, S_BLOCK, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [79:0]     r_key_sh;
    logic [6:0]      r_kcnt;
    logic [6:0]      w_key_idx;
    logic [BCW-1:0]  r_bc;
    logic            r_err;
    logic            r_core_rst_n;
    logic [7:0]      r_core_data;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_cnt;
    logic            w_full, w_pop, w_push, w_drop, w_fault;
    logic            w_sign_ok, w_accept, w_start_acc, w_err_set, w_timeout;

    assign w_sign_ok = (i_core_sign_reg == 8'h04);
    assign w_full    = (r_cnt == CNT_FULL);
    assign w_pop     = o_dout_valid && i_dout_ready;
    assign w_push    = i_core_wt_sgn && (!w_full || w_pop);
    assign w_drop    = i_core_wt_sgn && w_full && !w_pop;
    // A byte from the core outside a block is still stored but marks the session broken.
    assign w_fault   = w_drop || (i_core_wt_sgn && (r_state != S_BLOCK));

    assign o_core_fifo_cnd = w_full ? 2'b11 : ((r_cnt <= CNT_OPEN) ? 2'b00 : 2'b01);
    assign w_accept = (r_state == S_READY) && i_din_valid && w_sign_ok &&
                      (o_core_fifo_cnd == 2'b00) && !w_fault;

    // The core keeps the last 80 bits it sees, so the first (k=0) bit is a repeat of the MSB.
    assign w_key_idx = (r_kcnt == 7'd0) ? 7'd79 : (7'd80 - r_kcnt);

    assign o_din_ready       = w_accept;
    assign o_core_strob_data = w_accept;
    assign o_core_data       = w_accept ? i_din : r_core_data;
    assign o_core_strob_key  = (r_state == S_KEY);
    assign o_core_key        = (r_state == S_KEY) ? r_key_sh[w_key_idx] : 1'b0;
    assign o_core_rst_n      = r_core_rst_n;
    assign o_dout_valid      = (r_cnt != '0);
    assign o_dout            = o_dout_valid ? r_mem[r_rd] : 8'h00;
    assign o_busy            = (r_state != S_IDLE) && (r_state != S_ERR);
    assign o_err             = r_err;

`ifdef TRIVIUM_HOST_INIT_TIMEOUT_EN
    localparam int TW = $clog2(INIT_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(INIT_TIMEOUT - 1);
    logic [TW-1:0] r_tcnt;

    // Count cycles spent waiting for the core to finish initialising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_tcnt <= '0;
        else if (r_state == S_WAIT_INIT)   r_tcnt <= r_tcnt + TW'(1);
        else                               r_tcnt <= '0;
    end

    assign w_timeout = (r_state == S_WAIT_INIT) && (r_tcnt == TO_LAST);
`else
    // No timeout in this build: the comparison is constant false (INIT_TIMEOUT is never negative).
    assign w_timeout = (INIT_TIMEOUT < 0);
`endif

    // Next-state decode; faults from the core interface override any other transition.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (i_start) begin
                    w_next      = S_CRST;
                    w_start_acc = 1'b1;
                end
            end
            S_CRST:      w_next = S_KEY;
            S_KEY:       if (r_kcnt == 7'd80) w_next = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (w_sign_ok) begin
                    w_next = S_READY;
                end else if (w_timeout) begin
                    w_next    = S_ERR;
                    w_err_set = 1'b1;
                end
            end
            S_READY:     if (w_accept) w_next = S_BLOCK;
            S_BLOCK:     if (i_core_wt_sgn && (r_bc == BC_LAST)) w_next = S_READY;
            default:     w_next = S_IDLE;
        endcase
        if (w_fault) begin
            w_next      = S_ERR;
            w_err_set   = 1'b1;
            w_start_acc = 1'b0;
        end
    end

    // Control state, key shifter, counters and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_key_sh     <= '0;
            r_kcnt       <= '0;
            r_bc         <= '0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b1;
            r_core_data  <= 8'h00;
        end else begin
            r_state      <= w_next;
            r_core_rst_n <= (w_next != S_CRST);
            if (w_start_acc) r_key_sh <= i_key_in;
            if (w_err_set)        r_err <= 1'b1;
            else if (w_start_acc) r_err <= 1'b0;
            r_kcnt <= ((r_state == S_KEY) && (w_next == S_KEY)) ? (r_kcnt + 7'd1) : 7'd0;
            if (w_accept) begin
                r_bc        <= '0;
                r_core_data <= i_din;
            end else if ((r_state == S_BLOCK) && i_core_wt_sgn) begin
                r_bc <= r_bc + BCW'(1);
            end
        end
    end

    // Ciphertext storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_core_stream;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_host_ctrl.sv
// Self-checking bench for trivium_host_ctrl: key load, block flow, FIFO backpressure/overflow, init timeout, async reset.
// Ciphertext bytes are tracked in a queue model that mirrors FIFO occupancy and contents.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_trivium_host_ctrl;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_din_valid, i_dout_ready, i_core_wt_sgn;
    logic [79:0] i_key_in;
    logic [7:0]  i_din, i_core_stream, i_core_sign_reg;
    logic        o_din_ready, o_dout_valid, o_core_rst_n, o_core_key, o_core_strob_key;
    logic        o_core_strob_data, o_busy, o_err;
    logic [7:0]  o_dout, o_core_data;
    logic [1:0]  o_core_fifo_cnd;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] q[$];

    typedef struct {
        logic       vld;
        logic [7:0] sign;
        logic [7:0] din;
        logic       exp_rdy;
        logic [7:0] exp_data;
    } gate_vec_t;
    gate_vec_t tv[5];

    trivium_host_ctrl #(.FIFO_DEPTH(512), .BLOCK_LEN(256), .INIT_TIMEOUT(2048)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_key_in(i_key_in),
        .i_din(i_din), .i_din_valid(i_din_valid), .o_din_ready(o_din_ready),
        .o_dout(o_dout), .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready),
        .o_core_rst_n(o_core_rst_n), .o_core_key(o_core_key), .o_core_strob_key(o_core_strob_key),
        .o_core_data(o_core_data), .o_core_strob_data(o_core_strob_data),
        .o_core_fifo_cnd(o_core_fifo_cnd),
        .i_core_stream(i_core_stream), .i_core_wt_sgn(i_core_wt_sgn),
        .i_core_sign_reg(i_core_sign_reg),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_cnd();
        if (q.size() == DEPTH)        return 2'b11;
        else if (q.size() <= DEPTH - 256) return 2'b00;
        else                          return 2'b01;
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_din_ready"},  o_din_ready, 0);
        chk({tag, "_dout"},       o_dout, 0);
        chk({tag, "_dout_valid"}, o_dout_valid, 0);
        chk({tag, "_core_rst_n"}, o_core_rst_n, 1);
        chk({tag, "_core_key"},   o_core_key, 0);
        chk({tag, "_strob_key"},  o_core_strob_key, 0);
        chk({tag, "_core_data"},  o_core_data, 0);
        chk({tag, "_strob_data"}, o_core_strob_data, 0);
        chk({tag, "_fifo_cnd"},   o_core_fifo_cnd, 0);
        chk({tag, "_busy"},       o_busy, 0);
        chk({tag, "_err"},        o_err, 0);
    endtask

    // One clock: optionally present a core byte, score any pop, and advance past the edge.
    task automatic cycle(input logic wt, input logic [7:0] b);
        bit pop;
        i_core_wt_sgn = wt;
        i_core_stream = b;
        #1;
        chk("dout_valid", o_dout_valid, (q.size() > 0));
        pop = i_dout_ready && (q.size() > 0);
        if (pop) begin
            chk("dout_byte", o_dout, q[0]);
            void'(q.pop_front());
        end
        if (wt && (q.size() < DEPTH)) q.push_back(b);
        @(posedge clk); #1;
        i_core_wt_sgn = 1'b0;
    endtask

    // Pulse start and watch the reset and serial key phases for 100 cycles.
    task automatic key_load(input logic [79:0] key, output int last_c);
        int lo, hi;
        bit bad_order;
        logic [80:0] bits;
        lo = 0; hi = 0; bad_order = 0; bits = '0; last_c = -1;
        i_key_in = key;
        i_start  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            i_start  = 1'b0;
            i_key_in = '0;
            if (!o_core_rst_n) begin
                lo++;
                if (hi != 0) bad_order = 1;
            end
            if (o_core_strob_key) begin
                hi++;
                bits = {bits[79:0], o_core_key};
                if (lo == 0) bad_order = 1;
                last_c = c;
            end
        end
        chk("core_rst_low_cycles", lo, 1);
        chk("strob_key_cycles", hi, 81);
        chk("key_bits_k1_80", bits[79:0], key);
        chk("key_bit_k0", bits[80], key[79]);
        chk("rst_before_key", bad_order, 0);
        chk("busy_after_key", o_busy, 1);
        chk("err_after_key", o_err, 0);
    endtask

    initial begin
        int last_c, first, errs, pulses, n;
        bit acc, exp_acc;

        rst = 1'b0;
        i_start = 0; i_din_valid = 0; i_dout_ready = 0; i_core_wt_sgn = 0;
        i_key_in = '0; i_din = 0; i_core_stream = 0; i_core_sign_reg = 8'h00;

        tv[0] = '{1'b0, 8'h04, 8'h11, 1'b0, 8'h00};
        tv[1] = '{1'b1, 8'h02, 8'h22, 1'b0, 8'h00};
        tv[2] = '{1'b1, 8'h08, 8'h33, 1'b0, 8'h00};
        tv[3] = '{1'b1, 8'h00, 8'h44, 1'b0, 8'h00};
        tv[4] = '{1'b1, 8'h04, 8'h5A, 1'b1, 8'h5A};

        #12;
        reset_checks("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Key load with the core reporting "not ready".
        i_core_sign_reg = 8'h02;
        key_load(80'h0123456789ABCDEF0123, last_c);

`ifdef TRIVIUM_HOST_INIT_TIMEOUT_EN
        first = -1;
        for (int c = 100; c < 2400 && first < 0; c++) begin
            @(posedge clk); #1;
            if (o_err) first = c;
        end
        chk("timeout_cycle", first, last_c + 2049);
        chk("timeout_busy", o_busy, 0);
        key_load(80'hFEDCBA98765432100F1E, last_c);
`else
        errs = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (o_err) errs++;
        end
        chk("no_timeout_err", errs, 0);
        chk("no_timeout_busy", o_busy, 1);
        // start outside IDLE/ERR must not restart the core.
        i_key_in = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        i_start  = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("start_ignored_rst", o_core_rst_n, 1);
        @(posedge clk); #1;
        chk("start_ignored_key", o_core_strob_key, 0);
`endif

        // Core ready: table of READY-state gating vectors.
        i_core_sign_reg = 8'h04;
        @(posedge clk); #1;
        chk("ready_cnd", o_core_fifo_cnd, 2'b00);
        for (int i = 0; i < 5; i++) begin
            i_din_valid     = tv[i].vld;
            i_core_sign_reg = tv[i].sign;
            i_din           = tv[i].din;
            #1;
            chk("gate_din_ready", o_din_ready, tv[i].exp_rdy);
            chk("gate_strob_data", o_core_strob_data, tv[i].exp_rdy);
            chk("gate_core_data", o_core_data, tv[i].exp_data);
            @(posedge clk); #1;
        end
        i_din_valid = 1'b0;
        i_core_sign_reg = 8'h04;

        // Block 1: back-to-back bytes, consumer stalled.
        i_din_valid = 1'b1;
        #1;
        chk("block_din_ready", o_din_ready, 0);
        i_din_valid = 1'b0;
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'((i * 7 + 3) & 255));
        chk("blk1_cnd", o_core_fifo_cnd, 2'b00);
        chk("blk1_busy", o_busy, 1);

        // Block 2 with gaps between core bytes.
        i_din_valid = 1'b1;
        i_din = 8'hA7;
        #1;
        chk("blk2_din_ready", o_din_ready, 1);
        chk("blk2_core_data", o_core_data, 8'hA7);
        cycle(1'b0, 8'h00);
        i_din_valid = 1'b0;
        #1;
        chk("blk2_held_data", o_core_data, 8'hA7);
        pulses = 0;
        for (int i = 0; i < 600 && pulses < 256; i++) begin
            if ((i % 3) != 0) begin
                cycle(1'b1, 8'((i * 13 + 1) & 255));
                pulses++;
            end else begin
                cycle(1'b0, 8'h00);
            end
        end
        chk("blk2_cnd_full", o_core_fifo_cnd, 2'b11);

        // Third byte must wait until the FIFO drains to a whole block of space.
        i_din_valid = 1'b1;
        i_din = 8'h3C;
        #1;
        chk("full_din_ready", o_din_ready, 0);
        i_dout_ready = 1'b1;
        acc = 0;
        for (n = 0; n < 300 && !acc; n++) begin
            #1;
            exp_acc = (q.size() <= DEPTH - 256);
            chk("drain_din_ready", o_din_ready, exp_acc);
            chk("drain_cnd", o_core_fifo_cnd, exp_cnd());
            acc = exp_acc;
            cycle(1'b0, 8'h00);
        end
        chk("third_accepted", acc, 1);
        i_din_valid = 1'b0;
        i_dout_ready = 1'b0;

        // Block 3 brings the FIFO to 511; stray bytes then push, error, and finally drop.
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(255 - i));
        chk("blk3_cnd", o_core_fifo_cnd, 2'b01);
        cycle(1'b1, 8'hE1);
        chk("stray_err", o_err, 1);
        chk("stray_busy", o_busy, 0);
        chk("stray_cnd", o_core_fifo_cnd, 2'b11);
        cycle(1'b1, 8'hE2);
        chk("ovf_err", o_err, 1);
        chk("ovf_cnd", o_core_fifo_cnd, 2'b11);

        // Re-key from ERR: error clears, FIFO contents survive.
        key_load(80'hA5A5_5A5A_0F0F_F0F0_C3C3, last_c);
        chk("rekey_cnd", o_core_fifo_cnd, 2'b11);
        i_dout_ready = 1'b1;
        for (n = 0; n < 700 && q.size() > 0; n++) cycle(1'b0, 8'h00);
        chk("drained_valid", o_dout_valid, 0);
        chk("drained_cnd", o_core_fifo_cnd, 2'b00);
        i_dout_ready = 1'b0;

        // Async reset in the middle of a block.
        i_din_valid = 1'b1;
        i_din = 8'h77;
        #1;
        chk("blk4_din_ready", o_din_ready, 1);
        cycle(1'b0, 8'h00);
        i_din_valid = 1'b0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 8'(i));
        chk("mid_block_valid", o_dout_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        reset_checks("midrst");
        q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", o_dout_valid, 0);
        chk("post_rst_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
